// File: rtl/seg7_scan_if.sv
// seg7_scan_if: word/control bundle between the CPU-side driver and the
// 7-segment scanner.
//   data_a, data_b : candidate words (CPU pc / inst)
//   sel            : 0 = data_a, 1 = data_b (sampled at shadow load)
//   freeze         : inhibit shadow reload at frame wrap
//   an, seg        : active-low digit enables / segments {dp,g..a}
//   frame_done     : one-cycle pulse after the digit-7 -> digit-0 wrap
// master = word source / board side, slave = the scanner.
interface seg7_scan_if;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        sel;
    logic        freeze;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    modport master (
        output data_a, data_b, sel, freeze,
        input  an, seg, frame_done
    );

    modport slave (
        input  data_a, data_b, sel, freeze,
        output an, seg, frame_done
    );
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexes one 32-bit word as 8 hex digits onto a
// common-anode 7-segment board. The word is captured into a shadow register
// once per frame so a digit never shows a mix of old and new values.
//   clk  : system clock
//   rst  : synchronous reset, active-low
//   bus  : seg7_scan_if.slave (data_a, data_b, sel, freeze in;
//          an, seg, frame_done out)
// Parameter SCAN_DIV (2..2^20): clock cycles each digit stays lit.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN: blank leading zero digits
// (digit 0 always shown).
module seg7_scan #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic [31:0]      shadow;
    logic             load_pend;

    logic             tick;
    logic             wrap;
    logic [3:0]       nib;
    logic [7:0]       seg_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign wrap = tick && (idx == 3'd7);
    assign nib  = shadow[{idx, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // blank[i]: nibble i and everything above it are zero. Derived from the
    // shadow only, so the mask is constant across a frame.
    logic [7:0] blank;
    always_comb begin
        blank = '0;
        for (int i = 1; i < 8; i++)
            blank[i] = ((shadow >> (4 * i)) == 32'd0);
    end
    assign seg_nxt = blank[idx] ? 8'hFF : {1'b1, hex7(nib)};
`else
    assign seg_nxt = {1'b1, hex7(nib)};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt        <= '0;
            idx            <= '0;
            shadow         <= '0;
            load_pend      <= 1'b1;
            bus.an         <= 8'hFF;
            bus.seg        <= 8'hFF;
            bus.frame_done <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                idx <= idx + 3'd1;
            bus.frame_done <= wrap;

            // First cycle out of reset always loads, regardless of freeze,
            // so the board never shows the zeroed reset shadow for a frame.
            if (load_pend || (wrap && !bus.freeze))
                shadow <= bus.sel ? bus.data_b : bus.data_a;
            load_pend <= 1'b0;

            // Outputs follow idx/shadow as they were before this edge.
            bus.an  <= ~(8'h01 << idx);
            bus.seg <= seg_nxt;
        end
    end
endmodule

// File: tb/tb_seg7_scan.sv
module tb_seg7_scan;
    localparam int S = 4;
    localparam int FRAME = 8 * S;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_if bus ();

    seg7_scan #(.SCAN_DIV(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Segment codes {g..a} for digits 0..F.
    logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                 7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: n = edges since reset release. The digit shown after
    // edge n is ((n-1)/S)%8; a frame wraps at every edge n that is a
    // multiple of 8*S; the word loads at n==1 and at unfrozen wraps.
    int          n = 0;
    int          digit;
    logic [31:0] m_shadow = '0;
    logic [31:0] hi;
    exp_t        e_m;

    always @(posedge clk) begin
        if (!rst) begin
            n        = 0;
            m_shadow = '0;
            e_m      = '{an: 8'hFF, seg: 8'hFF, fd: 1'b0};
        end else begin
            n      = n + 1;
            digit  = ((n - 1) / S) % 8;
            hi     = m_shadow >> (4 * digit);
            e_m.an = ~(8'h01 << digit);
            e_m.seg = {1'b1, hex_tbl[hi[3:0]]};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (digit > 0 && hi == 32'd0)
                e_m.seg = 8'hFF;
`endif
            e_m.fd = (n % FRAME) == 0;
            if (n == 1 || (e_m.fd && !bus.freeze))
                m_shadow = bus.sel ? bus.data_b : bus.data_a;
        end
        q.push_back(e_m);
    end

    // Monitor: every cycle the board presents a new output word.
    exp_t e_d;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e_d = q.pop_front();
            n_checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== e_d) begin
                n_fail++;
                $display("FAIL scan t=%0t: got an=%h seg=%h fd=%b, expected an=%h seg=%h fd=%b",
                         $time, bus.an, bus.seg, bus.frame_done, e_d.an, e_d.seg, e_d.fd);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_an(input logic [7:0] target);
        bit hit = 0;
        for (int i = 0; i < 2 * FRAME + 4 && !hit; i++) begin
            @(negedge clk);
            if (bus.an === target) hit = 1;
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL wait_an timeout: an=%h never reached %h", bus.an, target);
        end
    endtask

    task automatic wait_fd();
        bit hit = 0;
        for (int i = 0; i < 2 * FRAME + 4 && !hit; i++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) hit = 1;
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL wait_fd timeout: frame_done never pulsed");
        end
    endtask

    initial begin
        bus.data_a = 32'h0040_0000;
        bus.data_b = 32'h0;
        bus.sel    = 1'b0;
        bus.freeze = 1'b0;
        rst        = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_an", bus.an, 8'hFF);
        chk("reset_seg", bus.seg, 8'hFF);
        rst = 1'b1;
        @(negedge clk);
        chk("first_an", bus.an, 8'hFE);
        chk("first_seg", bus.seg, 8'hC0);
        wait_an(8'hDF);
        chk("digit5_is_4", bus.seg, 8'h99);

        // Mid-frame select change stays hidden until the wrap.
        wait_an(8'hEF);
        bus.sel    = 1'b1;
        bus.data_b = 32'h3C08_1001;
        wait_an(8'hDF);
        chk("tearfree_digit5", bus.seg, 8'h99);
        wait_fd();
        wait_an(8'hFE);
        chk("sel_b_digit0", bus.seg, 8'hF9);
        wait_an(8'h7F);
        chk("sel_b_digit7", bus.seg, 8'hB0);

        // Freeze holds the captured word across wraps.
        bus.sel = 1'b0;
        bus.data_a = 32'h0040_0000;
        wait_fd();
        wait_an(8'hEF);
        bus.freeze = 1'b1;
        bus.data_a = 32'hFFFF_FFFF;
        wait_fd();
        wait_fd();
        wait_an(8'hDF);
        chk("frozen_digit5", bus.seg, 8'h99);
        bus.freeze = 1'b0;
        wait_fd();
        wait_an(8'hFE);
        chk("unfrozen_digit0", bus.seg, 8'h8E);
        wait_an(8'h7F);
        chk("unfrozen_digit7", bus.seg, 8'h8E);

        // Reset mid-frame: load_pend reload ignores freeze.
        bus.freeze = 1'b1;
        bus.data_a = 32'h1234_5678;
        wait_an(8'hDF);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_an", bus.an, 8'hFF);
        chk("midreset_seg", bus.seg, 8'hFF);
        rst = 1'b1;
        @(negedge clk);
        chk("restart_an", bus.an, 8'hFE);
        wait_an(8'hFD);
        chk("reload_digit1", bus.seg, 8'hF8);

        // Leading-zero cases.
        bus.freeze = 1'b0;
        bus.data_a = 32'h0000_00A5;
        wait_fd();
        wait_an(8'hFE);
        chk("a5_digit0", bus.seg, 8'h92);
        wait_an(8'hFD);
        chk("a5_digit1", bus.seg, 8'h88);
        wait_an(8'h7F);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        chk("a5_digit7_blank", bus.seg, 8'hFF);
`else
        chk("a5_digit7_zero", bus.seg, 8'hC0);
`endif
        bus.data_a = 32'h0;
        wait_fd();
        wait_an(8'hFE);
        chk("zero_digit0", bus.seg, 8'hC0);
        wait_an(8'hFD);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        chk("zero_digit1_blank", bus.seg, 8'hFF);
`else
        chk("zero_digit1", bus.seg, 8'hC0);
`endif

        // Randomized traffic, checked by the scoreboard.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0)
                bus.data_a = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 19) == 0)
                bus.data_b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 29) == 0)
                bus.sel = ~bus.sel;
            if ($urandom_range(0, 39) == 0)
                bus.freeze = ~bus.freeze;
            rst = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
